// File: rtl/uart_xmit.sv
// UART transmitter: one-byte holding register in front of a shift register.
// Frame: start(0), 8 data bits LSB first, parity, STOP_BITS stop bits (1).
// Each serial bit lasts OVERSAMPLE clock cycles. All outputs are registered.
module uart_xmit #(
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        WR,
    input  logic [31:0] Din,
    output logic        TxD,
    output logic        TxRDY,
    output logic        TxBusy
);

    localparam int             CW      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(OVERSAMPLE - 1);
    localparam logic           SB_MAX  = (STOP_BITS > 1);
    localparam logic           ODD     = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t         state;
    logic [7:0]     holding;
    logic [7:0]     shifter;
    logic           par;
    logic [CW-1:0]  cnt;
    logic [2:0]     idx;
    logic           sbit;
    logic           bit_end;

    // Upper write-data bits carry nothing for this block.
    logic unused_din;
    assign unused_din = ^Din[31:8];

    // Last clock cycle of the current serial bit.
    assign bit_end = (cnt == CNT_MAX);

    // Holding register write, frame sequencing and serial output, all in one FSM.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            holding <= '0;
            shifter <= '0;
            par     <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            sbit    <= 1'b0;
            TxD     <= 1'b1;
            TxRDY   <= 1'b1;
            TxBusy  <= 1'b0;
        end else begin
            // TxRDY doubles as the "holding empty" flag; a write while full is dropped.
            // A transfer below only happens when holding is full, so the two never collide.
            if (WR && TxRDY) begin
                holding <= Din[7:0];
                TxRDY   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    TxD    <= 1'b1;
                    TxBusy <= 1'b0;
                    cnt    <= '0;
                    if (!TxRDY) begin
                        shifter <= holding;
                        par     <= (^holding) ^ ODD;
                        TxRDY   <= 1'b1;
                        state   <= START;
                        TxD     <= 1'b0;
                        TxBusy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= DATA;
                        TxD   <= shifter[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
                            idx   <= '0;
                            state <= PARITY;
                            TxD   <= par;
                        end else begin
                            idx <= idx + 3'd1;
                            TxD <= shifter[idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        sbit  <= 1'b0;
                        state <= STOP;
                        TxD   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (sbit == SB_MAX) begin
                            sbit <= 1'b0;
                            // Back-to-back: chain straight into the next start bit.
                            if (!TxRDY) begin
                                shifter <= holding;
                                par     <= (^holding) ^ ODD;
                                TxRDY   <= 1'b1;
                                state   <= START;
                                TxD     <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                TxD    <= 1'b1;
                                TxBusy <= 1'b0;
                            end
                        end else begin
                            sbit <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    TxD    <= 1'b1;
                    TxBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_xmit.sv
// Bench for uart_xmit: an even-parity and an odd-parity instance driven in parallel.
module tb_uart_xmit;

    logic        Clock;
    logic        Reset;
    logic        WR;
    logic [31:0] Din;
    logic        txd_e, rdy_e, busy_e;
    logic        txd_o, rdy_o, busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    uart_xmit #(.OVERSAMPLE(16), .PARITY_ODD(0), .STOP_BITS(1)) dut_even (
        .Clock(Clock), .Reset(Reset), .WR(WR), .Din(Din),
        .TxD(txd_e), .TxRDY(rdy_e), .TxBusy(busy_e)
    );

    uart_xmit #(.OVERSAMPLE(16), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
        .Clock(Clock), .Reset(Reset), .WR(WR), .Din(Din),
        .TxD(txd_o), .TxRDY(rdy_o), .TxBusy(busy_o)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] din;
        logic       pe;   // expected even parity bit
        logic       po;   // expected odd parity bit
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single-cycle write; on return we sit on the negedge after the accepting edge.
    task automatic write_byte(input logic [7:0] b);
        @(negedge Clock);
        WR  = 1'b1;
        Din = {24'hDEADBE, b};
        @(negedge Clock);
        WR  = 1'b0;
        chk("rdy_after_wr", {rdy_e, rdy_o}, 2'b00);
    endtask

    // Count negedges until the start bit appears; expected latency is 2.
    task automatic wait_start();
        int lat = 1;
        while (txd_e !== 1'b0 && lat < 40) begin
            @(negedge Clock);
            lat++;
        end
        chk("start_latency", lat, 2);
        chk("start_both", {txd_e, txd_o, busy_e, busy_o}, 4'b0011);
        chk("rdy_after_xfer", {rdy_e, rdy_o}, 2'b11);
    endtask

    // Called on the first negedge of a start bit; samples each bit mid-way.
    task automatic capture(output logic [10:0] fe, output logic [10:0] fo, output logic ok);
        ok = busy_e & busy_o;
        fe = '0;
        fo = '0;
        for (int m = 1; m <= 168; m++) begin
            @(negedge Clock);
            ok = ok & busy_e & busy_o;
            if (m % 16 == 8) begin
                fe[m/16] = txd_e;
                fo[m/16] = txd_o;
            end
        end
        chk("busy_in_frame", ok, 1);
    endtask

    task automatic check_frame(input logic [10:0] fe, input logic [10:0] fo,
                               input logic [7:0] d, input logic pe, input logic po);
        chk("frame_even", fe, {1'b1, pe, d, 1'b0});
        chk("frame_odd",  fo, {1'b1, po, d, 1'b0});
    endtask

    // From the stop-bit midpoint to 176 cycles after the start: busy holds, then idle.
    task automatic end_check();
        logic ok = 1'b1;
        for (int m = 169; m <= 175; m++) begin
            @(negedge Clock);
            ok = ok & busy_e & busy_o & txd_e & txd_o;
        end
        chk("stop_hold", ok, 1);
        @(negedge Clock);
        chk("idle_after_frame", {txd_e, txd_o, busy_e, busy_o, rdy_e, rdy_o}, 6'b110011);
    endtask

    initial begin
        vec_t       tbl[6];
        logic [10:0] fe, fo, fe2, fo2;
        logic        ok;

        tbl[0] = '{8'h9D, 1'b1, 1'b0};
        tbl[1] = '{8'h99, 1'b0, 1'b1};
        tbl[2] = '{8'h00, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 1'b0, 1'b1};
        tbl[4] = '{8'h01, 1'b1, 1'b0};
        tbl[5] = '{8'h80, 1'b1, 1'b0};

        Reset = 1'b0;
        WR    = 1'b0;
        Din   = '0;
        repeat (3) @(negedge Clock);
        chk("reset_state", {txd_e, rdy_e, busy_e, txd_o, rdy_o, busy_o}, 6'b110110);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        // Table-driven single frames, checked on both parity flavours.
        for (int i = 0; i < 6; i++) begin
            write_byte(tbl[i].din);
            wait_start();
            capture(fe, fo, ok);
            check_frame(fe, fo, tbl[i].din, tbl[i].pe, tbl[i].po);
            end_check();
            repeat (3) @(negedge Clock);
        end

        // Back-to-back: second byte written as soon as the first leaves holding.
        write_byte(8'h9D);
        wait_start();
        fork
            capture(fe, fo, ok);
            write_byte(8'h99);
        join
        check_frame(fe, fo, 8'h9D, 1'b1, 1'b0);
        ok = 1'b1;
        for (int m = 169; m <= 175; m++) begin
            @(negedge Clock);
            ok = ok & busy_e & busy_o & txd_e & txd_o;
        end
        chk("b2b_gap_busy", ok, 1);
        @(negedge Clock);
        chk("b2b_start_at_176", {txd_e, txd_o, busy_e, busy_o}, 4'b0011);
        capture(fe2, fo2, ok);
        check_frame(fe2, fo2, 8'h99, 1'b0, 1'b1);
        end_check();
        repeat (3) @(negedge Clock);

        // Overrun: second write while holding full is dropped.
        @(negedge Clock);
        WR  = 1'b1;
        Din = 32'h0000_00A5;
        @(negedge Clock);
        Din = 32'h0000_003C;
        chk("ovr_rdy_full", {rdy_e, rdy_o}, 2'b00);
        @(negedge Clock);
        WR  = 1'b0;
        chk("ovr_start", {txd_e, txd_o, busy_e, busy_o}, 4'b0011);
        capture(fe, fo, ok);
        check_frame(fe, fo, 8'hA5, 1'b0, 1'b1);
        end_check();
        ok = 1'b1;
        for (int m = 0; m < 40; m++) begin
            @(negedge Clock);
            ok = ok & txd_e & txd_o & ~busy_e & ~busy_o;
        end
        chk("ovr_no_second_frame", ok, 1);

        // Reset in the middle of data bit 3, then a clean frame.
        write_byte(8'h55);
        wait_start();
        repeat (72) @(negedge Clock);
        chk("mid_bit3_level", {txd_e, txd_o}, 2'b00);
        Reset = 1'b0;
        #1;
        chk("async_abort", {txd_e, rdy_e, busy_e, txd_o, rdy_o, busy_o}, 6'b110110);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        write_byte(8'h55);
        wait_start();
        capture(fe, fo, ok);
        check_frame(fe, fo, 8'h55, 1'b0, 1'b1);
        end_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
